hazard_fwd_unit: RTL

Forwarding and load-use hazard unit for the 5-stage RV32I pipeline. It keeps a shadow copy of destination-register and control state for the EX, MEM and WB stages. While an instruction sits in ID, the unit decides the ALU operand sources that instruction will need in EX and registers them, so `fwd_a_o`/`fwd_b_o` drive the two EX-stage 3-input operand muxes directly. It also raises the load-use stall and inserts a bubble.

---
 rtl/hazard_fwd_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// Forwarding and load-use hazard unit for the 5-stage RV32I pipeline.
// Shadows EX/MEM/WB destination state and drives registered EX operand selects.
//
// Ports:
//   clk_i, rst_n_i        clock, async active-low reset
//   hold_i                global freeze of all state (memory wait)
//   id_*                  decoded ID-stage instruction fields
//   ex_flush_i            taken branch/jump in EX, kills IF and ID
//   stall_o               combinational load-use stall (hold PC, IF/ID; bubble EX)
//   fwd_a_o, fwd_b_o      registered EX operand selects
//                         00 = regfile, 01 = EX/MEM result, 10 = MEM/WB data
//   stall_cnt_o,          perf counters, present only when HAZARD_PERF_EN
//   flush_cnt_o           is defined
//
// Build option: `define HAZARD_PERF_EN adds the stall/flush counters.

module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              hold_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              ex_flush_i,
    output logic              stall_o,
    output logic [1:0]        fwd_a_o,
`ifdef HAZARD_PERF_EN
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`else
    output logic [1:0]        fwd_b_o
`endif
);

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    // shadow pipeline state
    logic              ex_v;
    logic              ex_rw;
    logic              ex_mr;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_v;
    logic              mem_rw;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_v;
    logic              wb_rw;
    logic [REG_AW-1:0] wb_rd;

    logic              lu;
    logic              bubble;
    logic              rs1_ex;
    logic              rs1_mem;
    logic              rs2_ex;
    logic              rs2_mem;
    logic [1:0]        fwd_a_d;
    logic [1:0]        fwd_b_d;

    // a live writer of a non-zero register r
    function automatic logic prod(
        input logic              v,
        input logic              rw,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] r
    );
        return v & rw & (rd == r) & (r != '0);
    endfunction

    assign rs1_ex  = prod(ex_v, ex_rw, ex_rd, id_rs1_i);
    assign rs2_ex  = prod(ex_v, ex_rw, ex_rd, id_rs2_i);
    assign rs1_mem = prod(mem_v, mem_rw, mem_rd, id_rs1_i);
    assign rs2_mem = prod(mem_v, mem_rw, mem_rd, id_rs2_i);

    // load in EX whose result the ID instruction needs next cycle
    assign lu = id_valid_i & ex_mr & ex_v & ex_rw
              & (ex_rd != '0)
              & ((id_rs1_used_i & (ex_rd == id_rs1_i))
               | (id_rs2_used_i & (ex_rd == id_rs2_i)));

    // a flush kills the stalled consumer anyway, so it takes priority
    assign stall_o = lu & ~ex_flush_i;
    assign bubble  = lu | ex_flush_i;

    // youngest producer (EX) beats the older one (MEM)
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (id_valid_i & ~bubble) begin
            if (id_rs1_used_i) begin
                if (rs1_ex) begin
                    fwd_a_d = FWD_EX;
                end else if (rs1_mem) begin
                    fwd_a_d = FWD_WB;
                end
            end
            if (id_rs2_used_i) begin
                if (rs2_ex) begin
                    fwd_b_d = FWD_EX;
                end else if (rs2_mem) begin
                    fwd_b_d = FWD_WB;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_v    <= 1'b0;
            ex_rw   <= 1'b0;
            ex_mr   <= 1'b0;
            ex_rd   <= '0;
            mem_v   <= 1'b0;
            mem_rw  <= 1'b0;
            mem_rd  <= '0;
            wb_v    <= 1'b0;
            wb_rw   <= 1'b0;
            wb_rd   <= '0;
            fwd_a_o <= FWD_RF;
            fwd_b_o <= FWD_RF;
        end else if (!hold_i) begin
            wb_v    <= mem_v;
            wb_rw   <= mem_rw;
            wb_rd   <= mem_rd;
            mem_v   <= ex_v;
            mem_rw  <= ex_rw;
            mem_rd  <= ex_rd;
            ex_v    <= id_valid_i & ~bubble;
            ex_rw   <= id_regwrite_i;
            ex_mr   <= id_memread_i;
            ex_rd   <= id_rd_i;
            fwd_a_o <= fwd_a_d;
            fwd_b_o <= fwd_b_d;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (!hold_i) begin
            if (stall_o) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (ex_flush_i) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end
`endif

    // WB shadow is a debug view; these checks keep it honest
    a_cfg: assert property (
        @(posedge clk_i) CNT_W >= 1
    );

    a_no_sel3: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        (fwd_a_o != 2'b11) && (fwd_b_o != 2'b11)
    );

    a_wb_shift: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        !hold_i |=> (wb_v == $past(mem_v))
                 && (wb_rw == $past(mem_rw))
                 && (wb_rd == $past(mem_rd))
    );

endmodule
